spectrum_color_mapper: RTL
==========================

Name: spectrum_color_mapper

Overview:
Downstream consumer and address source for the three 1024x8 colour-palette ROMs (R_LUT/G_LUT/B_LUT, 10-bit addr, 8-bit data, no clock enable, no output register). It takes a stream of audio spectrum magnitudes and saturates/scales each one to a 10-bit palette index. It drives that index to all three ROMs in parallel, realigns the ROM read data with its sideband, and emits RGB565 pixels on a valid/ready stream toward the display line buffer. The ROMs cannot stall, so backpressure is absorbed by a credit-controlled skid FIFO.

Parameters:
MAG_W, 16, magnitude input width (10..24)
SHIFT, 6, right shift applied to magnitude before saturation to 10 bits
LUT_LAT, 1, ROM read latency in clocks from lut_addr change to valid lut_*_data (1 for OUTPUT_REG=0, 2 for OUTPUT_REG=1)
FIFO_DEPTH, 4, skid FIFO entries; must be >= LUT_LAT+2

Ports:
clk  in  1  single clock for block and ROMs
rst  in  1  asynchronous, active-high reset
mag_data  in  MAG_W  unsigned spectrum magnitude
mag_valid  in  1  magnitude valid
mag_last  in  1  last bin of a spectrum frame
mag_ready  out  1  block accepts a magnitude this cycle
lut_addr  out  10  shared address to R/G/B palette ROMs
lut_r_data  in  8  R ROM read data
lut_g_data  in  8  G ROM read data
lut_b_data  in  8  B ROM read data
pix_data  out  16  RGB565 pixel
pix_valid  out  1  pixel valid
pix_last  out  1  pixel is last of frame
pix_ready  in  1  downstream accepts pixel

Behaviour:
- Clock/reset: one clock domain (clk); rst is asynchronous and active-high.
- Reset values: lut_addr=0, pix_data=0, pix_valid=0, pix_last=0, pipeline valid bits and FIFO pointers/count cleared. mag_ready=0 while rst is high.
- Reset mid-operation: in-flight samples and FIFO contents are discarded; no pixel is emitted for them.
- Accept rule: a sample is taken when mag_valid & mag_ready.
- Credit logic: mag_ready = !rst & ((inflight_cnt + fifo_cnt) < FIFO_DEPTH). Both counts are registered. inflight_cnt counts samples issued but not yet written to the FIFO (0..LUT_LAT+1).
- Index: idx = mag_data >> SHIFT. If the result is > 1023, idx = 1023 (saturate, no wrap).
- Pipeline stage A (accept edge): register lut_addr <= idx, along with a valid bit and the last bit. lut_addr holds its value when no sample is accepted.
- Delay line: valid and last pass through a shift line of LUT_LAT stages, so they coincide with lut_*_data exactly LUT_LAT cycles after lut_addr updates.
- FIFO write: on the aligned valid, push {last, r[7:3], g[7:2], b[7:3]}.
- Latency: with an empty FIFO and pix_ready=1, pix_valid rises LUT_LAT+2 cycles after the accept edge (3 cycles at default).
- Throughput: one pixel per clock with pix_ready held at 1.
- FIFO read: the FIFO is first-word-fall-through. pix_valid = (fifo_cnt != 0). pix_data and pix_last come from the head entry. Pop on pix_valid & pix_ready.
- Simultaneous push and pop: fifo_cnt is unchanged and pointers advance. FIFO overflow cannot occur by construction; an assertion is required in simulation.
- Output stability: pix_data and pix_last stay stable while pix_valid & !pix_ready.
- Sideband: mag_last maps 1:1 to pix_last. Ordering is strictly preserved.

Optional Feature:
- Macro: SPECTRUM_CMAP_SAT_CNT_EN.
- When defined: adds output sat_cnt [15:0], reset to 0. It increments by 1 on each accepted sample whose index was saturated, and sticks at 0xFFFF.
- Also adds input sat_clr [0:0], which zeroes the count synchronously. If sat_clr and a saturating accept occur in the same cycle, the result is 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, pix_ready=1, single mag_data=0x0040 with SHIFT=6 -> lut_addr=1 one cycle after accept. With ROM returning R=0xF8, G=0xFC, B=0xF8: pix_data=0xFFFF, pix_valid high exactly 3 cycles after accept, for 1 cycle.
2. Saturation: mag_data=0xFFFF -> lut_addr=1023. Under SPECTRUM_CMAP_SAT_CNT_EN, sat_cnt goes 0->1; asserting sat_clr then returns it to 0.
3. Backpressure: pix_ready=0, mag_valid held high with 10 samples queued -> exactly 4 accepted, then mag_ready=0. Raising pix_ready gives 10 pixels in order with no drops or duplicates, and pix_data stays stable while stalled.
4. Streaming: 1024-sample ramp 0..1023<<6 with pix_ready=1 -> one pixel per clock, mag_ready never low after the first accept, and pix_last asserted only on pixel 1023 when mag_last is set on sample 1023.
5. Random pix_ready (50%) with random mag_valid over 5000 samples -> scoreboard matches a reference model of the palette lookup, and the FIFO-overflow assertion never fires.
6. Assert rst for 1 cycle with 3 samples in flight and 2 pixels buffered -> pix_valid=0 next cycle and no stale pixels afterwards; the first post-reset sample is output correctly.

Source files
------------

// File: rtl/spectrum_color_mapper_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spectrum_color_mapper_if                                         |
// | Magnitude stream, palette ROM bus and RGB565 pixel stream.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface spectrum_color_mapper_if #(
  parameter int MAG_W = 16
);
  logic [MAG_W-1:0] mag_data;
  logic             mag_valid;
  logic             mag_last;
  logic             mag_ready;
  logic [9:0]       lut_addr;
  logic [7:0]       lut_r_data;
  logic [7:0]       lut_g_data;
  logic [7:0]       lut_b_data;
  logic [15:0]      pix_data;
  logic             pix_valid;
  logic             pix_last;
  logic             pix_ready;

  modport master (
    output mag_data, mag_valid, mag_last,
    input  mag_ready,
    input  lut_addr,
    output lut_r_data, lut_g_data, lut_b_data,
    input  pix_data, pix_valid, pix_last,
    output pix_ready
  );

  modport slave (
    input  mag_data, mag_valid, mag_last,
    output mag_ready,
    output lut_addr,
    input  lut_r_data, lut_g_data, lut_b_data,
    output pix_data, pix_valid, pix_last,
    input  pix_ready
  );
endinterface
`default_nettype wire

// File: rtl/spectrum_color_mapper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spectrum_color_mapper                                            |
// | Magnitude -> palette index -> RGB565 pixel with credit-based     |
// | skid FIFO. Optional SPECTRUM_CMAP_SAT_CNT_EN adds sat_cnt/clr.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module spectrum_color_mapper #(
  parameter int MAG_W      = 16,
  parameter int SHIFT      = 6,
  parameter int LUT_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  spectrum_color_mapper_if.slave  bus
`ifdef SPECTRUM_CMAP_SAT_CNT_EN
  ,
  input  wire logic               sat_clr,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_inf_w = $clog2(LUT_LAT + 2);
  localparam int c_sum_w = ((c_cnt_w > c_inf_w) ? c_cnt_w : c_inf_w) + 1;

  logic [MAG_W-1:0]   w_shifted;
  logic               w_sat;
  logic [9:0]         w_idx;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [c_sum_w-1:0] w_credit;
  logic               w_unused;

  logic [9:0]         r_addr;
  logic               r_a_valid;
  logic               r_a_last;
  logic [LUT_LAT-1:0] r_dl_valid;
  logic [LUT_LAT-1:0] r_dl_last;
  logic [c_inf_w-1:0] r_inflight;
  logic [c_cnt_w-1:0] r_fifo_cnt;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [16:0]        r_mem [FIFO_DEPTH];

  assign w_shifted = bus.mag_data >> SHIFT;

  generate
    if (MAG_W > 10) begin : g_sat_wide
      assign w_sat = |w_shifted[MAG_W-1:10];
    end else begin : g_sat_narrow
      assign w_sat = 1'b0;
    end
  endgenerate

  assign w_idx    = w_sat ? 10'h3FF : w_shifted[9:0];
  // Credits cover every sample between acceptance and FIFO exit, so the
  // non-stallable ROM path can never overrun the FIFO.
  assign w_credit = c_sum_w'(r_inflight) + c_sum_w'(r_fifo_cnt);
  assign bus.mag_ready = !rst && (w_credit < c_sum_w'(FIFO_DEPTH));
  assign w_accept = bus.mag_valid && bus.mag_ready;
  assign w_push   = r_dl_valid[LUT_LAT-1];
  assign w_pop    = bus.pix_valid && bus.pix_ready;
  assign w_unused = ^{bus.lut_r_data[2:0], bus.lut_g_data[1:0], bus.lut_b_data[2:0]};

  assign bus.lut_addr  = r_addr;
  assign bus.pix_valid = (r_fifo_cnt != '0);
  assign bus.pix_data  = bus.pix_valid ? r_mem[r_rd_ptr][15:0] : 16'h0000;
  assign bus.pix_last  = bus.pix_valid ? r_mem[r_rd_ptr][16] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_a_valid  <= 1'b0;
      r_a_last   <= 1'b0;
      r_dl_valid <= '0;
      r_dl_last  <= '0;
    end else begin
      r_a_valid <= w_accept;
      if (w_accept) begin
        r_addr   <= w_idx;
        r_a_last <= bus.mag_last;
      end
      r_dl_valid[0] <= r_a_valid;
      r_dl_last[0]  <= r_a_last;
      for (int i = 1; i < LUT_LAT; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_last[i]  <= r_dl_last[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + c_inf_w'(1);
        2'b01:   r_inflight <= r_inflight - c_inf_w'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + c_cnt_w'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - c_cnt_w'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_dl_last[LUT_LAT-1], bus.lut_r_data[7:3],
                          bus.lut_g_data[7:2], bus.lut_b_data[7:3]};
    end
  end

`ifdef SPECTRUM_CMAP_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (w_accept && w_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_fifo_cnt == c_cnt_w'(FIFO_DEPTH))));

endmodule
`default_nettype wire
